// File: rtl/net_pkg.sv
// Shared Ethernet/IPv4 constants, FSM state type and keep-mask helper
// for the 512-bit network receive path.
package net_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;

  localparam int          ETH_HDR_LEN    = 14;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          IP_MIN_HDR     = 20;

  // Byte offsets of the header fields inside the first beat.
  localparam int ETHERTYPE_OFS = 12;
  localparam int IP_TOTLEN_OFS = ETH_HDR_LEN + 2;

  typedef enum logic [1:0] {
    FIRST   = 2'd0,  // awaiting beat 0 of a frame
    PASS    = 2'd1,  // forwarding a frame unchanged
    TRIM    = 2'd2,  // forwarding while counting toward the trim beat
    DISCARD = 2'd3   // dropping padding until the input tlast
  } depad_state_t;

  // Keep mask with bits [last_idx:0] set.
  function automatic logic [KEEP_W-1:0] keep_mask(input logic [5:0] last_idx);
    logic [KEEP_W-1:0] mask;
    for (int i = 0; i < KEEP_W; i++) begin
      mask[i] = (i <= int'(last_idx));
    end
    return mask;
  endfunction

  // Byte n of a beat; byte 0 sits in the least significant bits.
  function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] data, input int n);
    return data[8*n +: 8];
  endfunction

endpackage

// File: rtl/ethernet_frame_depadding_512_if.sv
// 512-bit AXI4-Stream bundle (data/keep/last with valid/ready handshake).
interface axi_stream;
  import net_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/ethernet_frame_depadding_512.sv
// Strips Ethernet padding from IPv4 frames: the frame is cut after byte
// 14 + IP total length - 1, trailing beats are swallowed, and every frame
// actually shortened is counted. One registered output stage.
module ethernet_frame_depadding_512
  import net_pkg::*;
(
  input  logic        net_clk,
  input  logic        aresetn,
  axi_stream.slave    s_axis_net_rx,
  axi_stream.master   m_axis_net_rx,
  output logic [31:0] trimmed_frames
);

  depad_state_t state, state_nxt;

  logic [10:0] beat_cnt;
  logic [10:0] trim_beat;   // beat index that carries the last kept byte
  logic [5:0]  trim_lidx;   // byte index of the last kept byte in that beat

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [KEEP_W-1:0] m_keep;
  logic              m_last;

  logic              s_ready;
  logic              accept;
  logic              emit;
  logic              out_last;
  logic [KEEP_W-1:0] out_keep;
  logic              count_trim;

  // First-beat header decode.
  logic [15:0] ethertype;
  logic [15:0] ip_tot_len;
  logic [16:0] tgt_len;
  logic [16:0] tgt_last;
  logic [10:0] hdr_beat;
  logic [5:0]  hdr_lidx;
  logic        trimmable;
  logic [KEEP_W-1:0] trim_mask;
  logic        bytes_beyond;

  assign ethertype  = {get_byte(s_axis_net_rx.tdata, ETHERTYPE_OFS),
                       get_byte(s_axis_net_rx.tdata, ETHERTYPE_OFS + 1)};
  assign ip_tot_len = {get_byte(s_axis_net_rx.tdata, IP_TOTLEN_OFS),
                       get_byte(s_axis_net_rx.tdata, IP_TOTLEN_OFS + 1)};
  assign tgt_len    = 17'(ETH_HDR_LEN) + {1'b0, ip_tot_len};
  assign tgt_last   = tgt_len - 17'd1;
  assign hdr_beat   = tgt_last[16:6];
  assign hdr_lidx   = tgt_last[5:0];
  assign trimmable  = (ethertype == ETHERTYPE_IPV4) && (ip_tot_len >= 16'(IP_MIN_HDR));

  // The trim point comes from the live header on beat 0, from the stored copy later.
  assign trim_mask    = keep_mask((state == FIRST) ? hdr_lidx : trim_lidx);
  assign bytes_beyond = |(s_axis_net_rx.tkeep & ~trim_mask);

  // Padding beats are dropped, so DISCARD never needs the output register.
  assign s_ready = (state == DISCARD) || !m_valid || m_axis_net_rx.tready;
  assign accept  = s_axis_net_rx.tvalid && s_ready;

  assign s_axis_net_rx.tready = s_ready;
  assign m_axis_net_rx.tvalid = m_valid;
  assign m_axis_net_rx.tdata  = m_data;
  assign m_axis_net_rx.tkeep  = m_keep;
  assign m_axis_net_rx.tlast  = m_last;

  // FSM state register.
  always_ff @(posedge net_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!aresetn) state <= FIRST;
    else          state <= state_nxt;
  end

  // Next state, output beat shaping and trim detection.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    emit       = 1'b0;
    out_last   = s_axis_net_rx.tlast;
    out_keep   = s_axis_net_rx.tkeep;
    count_trim = 1'b0;

    unique case (state)
      FIRST: begin
        if (accept) begin
          emit = 1'b1;
          if (trimmable && (hdr_beat == 11'd0)) begin
            out_last = 1'b1;
            out_keep = s_axis_net_rx.tkeep & trim_mask;
            if (!s_axis_net_rx.tlast) begin
              state_nxt  = DISCARD;
              count_trim = 1'b1;
            end else begin
              count_trim = bytes_beyond;
            end
          end else if (s_axis_net_rx.tlast) begin
            state_nxt = FIRST;
          end else if (trimmable) begin
            state_nxt = TRIM;
          end else begin
            state_nxt = PASS;
          end
        end
      end

      PASS: begin
        if (accept) begin
          emit = 1'b1;
          if (s_axis_net_rx.tlast) state_nxt = FIRST;
        end
      end

      TRIM: begin
        if (accept) begin
          emit = 1'b1;
          if (beat_cnt == trim_beat) begin
            out_last = 1'b1;
            out_keep = s_axis_net_rx.tkeep & trim_mask;
            if (s_axis_net_rx.tlast) begin
              state_nxt  = FIRST;
              count_trim = bytes_beyond;
            end else begin
              state_nxt  = DISCARD;
              count_trim = 1'b1;
            end
          end else if (s_axis_net_rx.tlast) begin
            state_nxt = FIRST;
          end
        end
      end

      DISCARD: begin
        if (accept && s_axis_net_rx.tlast) state_nxt = FIRST;
      end

      default: state_nxt = FIRST;
    endcase
  end

  // Beat counter, captured trim point and trimmed-frame counter.
  always_ff @(posedge net_clk) begin
    if (!aresetn) begin
      beat_cnt       <= '0;
      trim_beat      <= '0;
      trim_lidx      <= '0;
      trimmed_frames <= '0;
    end else begin
      if (accept) begin
        beat_cnt <= (state_nxt == FIRST) ? 11'd0 : beat_cnt + 11'd1;
      end
      if ((state == FIRST) && accept) begin
        trim_beat <= hdr_beat;
        trim_lidx <= hdr_lidx;
      end
      if (count_trim) trimmed_frames <= trimmed_frames + 32'd1;
    end
  end

  // Output register: loads on every forwarded beat, holds while stalled.
  always_ff @(posedge net_clk) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (emit) begin
      m_valid <= 1'b1;
      m_keep  <= out_keep;
      m_last  <= out_last;
    end else if (m_axis_net_rx.tready) begin
      m_valid <= 1'b0;
    end
  end

  // Payload path.
  always_ff @(posedge net_clk) begin
    // NOTE: the data word is left out of reset; it is only observed while
    // m_valid=1, so resetting 512 flops would buy nothing.
    if (emit) m_data <= s_axis_net_rx.tdata;
  end

endmodule

// File: tb/tb_ethernet_frame_depadding_512.sv
// Scoreboard bench for ethernet_frame_depadding_512: a byte-level model
// queues the expected output beats per frame, a monitor pops and compares.
module tb_ethernet_frame_depadding_512;
  import net_pkg::*;

  typedef logic [7:0] frame_q_t[$];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  logic        net_clk = 1'b0;
  logic        aresetn;
  logic [31:0] trimmed_frames;

  axi_stream s_if ();
  axi_stream m_if ();

  ethernet_frame_depadding_512 dut (
    .net_clk        (net_clk),
    .aresetn        (aresetn),
    .s_axis_net_rx  (s_if),
    .m_axis_net_rx  (m_if),
    .trimmed_frames (trimmed_frames)
  );

  always #5 net_clk = ~net_clk;

  beat_t             sb[$];
  int                n_checks = 0;
  int                n_errors = 0;
  logic [31:0]       exp_trimmed = '0;
  int                out_beats = 0;
  logic [KEEP_W-1:0] last_out_keep = '0;
  bit                stall_en = 1'b0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] byte_mask(input logic [KEEP_W-1:0] k);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < KEEP_W; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic frame_q_t make_frame(input int len, input logic [15:0] etype,
                                          input logic [15:0] tot_len);
    frame_q_t fr;
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    fr[12] = etype[15:8];
    fr[13] = etype[7:0];
    fr[16] = tot_len[15:8];
    fr[17] = tot_len[7:0];
    return fr;
  endfunction

  // Reference model: depad at byte level, queue the resulting beats.
  task automatic push_expected(input frame_q_t fr);
    int          n;
    int          out_len;
    int          l;
    logic [15:0] et;
    logic [15:0] t;
    beat_t       e;
    n       = fr.size();
    out_len = n;
    et      = {fr[12], fr[13]};
    t       = {fr[16], fr[17]};
    l       = 14 + int'(t);
    if (et == 16'h0800 && t >= 16'd20 && n > l) begin
      out_len = l;
      exp_trimmed++;
    end
    for (int b = 0; b * 64 < out_len; b++) begin
      e = '0;
      for (int i = 0; i < 64; i++) begin
        if (b * 64 + i < out_len) begin
          e.data[8*i +: 8] = fr[b * 64 + i];
          e.keep[i]        = 1'b1;
        end
      end
      e.last = ((b + 1) * 64 >= out_len);
      sb.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                           input logic l);
    int budget;
    bit acc;
    budget      = 0;
    acc         = 1'b0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!acc && budget < 2000) begin
      @(negedge net_clk);
      acc = s_if.tready;
      @(posedge net_clk);
      #1;
      budget++;
    end
    if (!acc) check("send_timeout", DATA_W'(1'b0), DATA_W'(1'b1));
  endtask

  task automatic build_beat(input frame_q_t fr, input int b,
                            output logic [DATA_W-1:0] d, output logic [KEEP_W-1:0] k);
    for (int i = 0; i < 64; i++) begin
      if (b * 64 + i < fr.size()) begin
        d[8*i +: 8] = fr[b * 64 + i];
        k[i]        = 1'b1;
      end else begin
        d[8*i +: 8] = 8'($urandom);
        k[i]        = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input frame_q_t fr, input bit gap_en);
    int                nb;
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    nb = (fr.size() + 63) / 64;
    push_expected(fr);
    for (int b = 0; b < nb; b++) begin
      build_beat(fr, b, d, k);
      send_beat(d, k, b == nb - 1);
      if (gap_en && $urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge net_clk);
        #1;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || m_if.tvalid) && budget < 5000) begin
      @(posedge net_clk);
      #1;
      budget++;
    end
    if (budget >= 5000) check("drain_timeout", DATA_W'(sb.size()), DATA_W'(0));
  endtask

  task automatic run_one(input frame_q_t fr);
    out_beats = 0;
    send_frame(fr, 1'b0);
    drain();
  endtask

  // Downstream ready: always ready, or a coin toss per cycle when stalling.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge net_clk);
      #1;
      m_if.tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare on handshake, hold check on stall.
  initial begin
    bit    prev_stall;
    beat_t prev;
    beat_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge net_clk);
      if (!aresetn) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", DATA_W'(m_if.tvalid), DATA_W'(1'b1));
        check("stall_data", m_if.tdata, prev.data);
        check("stall_keep", DATA_W'(m_if.tkeep), DATA_W'(prev.keep));
        check("stall_last", DATA_W'(m_if.tlast), DATA_W'(prev.last));
      end
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", DATA_W'(1'b1), DATA_W'(1'b0));
        end else begin
          e = sb.pop_front();
          check("out_keep", DATA_W'(m_if.tkeep), DATA_W'(e.keep));
          check("out_last", DATA_W'(m_if.tlast), DATA_W'(e.last));
          check("out_data", m_if.tdata & byte_mask(e.keep), e.data & byte_mask(e.keep));
        end
        out_beats++;
        last_out_keep = m_if.tkeep;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev.data  = m_if.tdata;
      prev.keep  = m_if.tkeep;
      prev.last  = m_if.tlast;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_q_t          fr;
    int                len;
    int                kind;
    logic [15:0]       t;
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;

    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    repeat (3) @(posedge net_clk);
    #1;
    check("rst_valid", DATA_W'(m_if.tvalid), DATA_W'(1'b0));
    check("rst_keep", DATA_W'(m_if.tkeep), DATA_W'(0));
    check("rst_last", DATA_W'(m_if.tlast), DATA_W'(1'b0));
    check("rst_trimmed", DATA_W'(trimmed_frames), DATA_W'(0));
    aresetn = 1'b1;
    @(posedge net_clk);
    #1;
    check("rst_s_ready", DATA_W'(s_if.tready), DATA_W'(1'b1));

    // 60B IPv4, T=28 -> 42 bytes kept in one beat.
    run_one(make_frame(60, 16'h0800, 16'd28));
    check("ipv4_60_beats", DATA_W'(out_beats), DATA_W'(1));
    check("ipv4_60_keep", DATA_W'(last_out_keep), DATA_W'(64'h0000_03FF_FFFF_FFFF));
    check("ipv4_60_cnt", DATA_W'(trimmed_frames), DATA_W'(1));

    // ARP passes untouched.
    run_one(make_frame(60, 16'h0806, 16'd28));
    check("arp_keep", DATA_W'(last_out_keep), DATA_W'(64'h0FFF_FFFF_FFFF_FFFF));
    check("arp_cnt", DATA_W'(trimmed_frames), DATA_W'(1));

    // 1500B IPv4 with no padding: 24 beats, counter unchanged.
    run_one(make_frame(1500, 16'h0800, 16'd1486));
    check("ipv4_1500_beats", DATA_W'(out_beats), DATA_W'(24));
    check("ipv4_1500_cnt", DATA_W'(trimmed_frames), DATA_W'(1));

    // 128B IPv4, T=36 (L=50): beat 1 swallowed.
    run_one(make_frame(128, 16'h0800, 16'd36));
    check("ipv4_128_beats", DATA_W'(out_beats), DATA_W'(1));
    check("ipv4_128_keep", DATA_W'(last_out_keep), DATA_W'(64'h0003_FFFF_FFFF_FFFF));
    check("ipv4_128_cnt", DATA_W'(trimmed_frames), DATA_W'(2));

    // L=64: trim point is the last byte of beat 0.
    run_one(make_frame(128, 16'h0800, 16'd50));
    check("l64_beats", DATA_W'(out_beats), DATA_W'(1));
    check("l64_keep", DATA_W'(last_out_keep), DATA_W'(64'hFFFF_FFFF_FFFF_FFFF));
    check("l64_cnt", DATA_W'(trimmed_frames), DATA_W'(3));

    // L=65: trim point is byte 0 of beat 1, which is also the input tlast beat.
    run_one(make_frame(128, 16'h0800, 16'd51));
    check("l65_beats", DATA_W'(out_beats), DATA_W'(2));
    check("l65_keep", DATA_W'(last_out_keep), DATA_W'(64'h1));
    check("l65_cnt", DATA_W'(trimmed_frames), DATA_W'(4));

    // L equals the real length: forwarded, not counted.
    run_one(make_frame(100, 16'h0800, 16'd86));
    check("exact_beats", DATA_W'(out_beats), DATA_W'(2));
    check("exact_cnt", DATA_W'(trimmed_frames), DATA_W'(4));

    // T below the minimum header: forwarded whole.
    run_one(make_frame(60, 16'h0800, 16'd10));
    check("short_t_keep", DATA_W'(last_out_keep), DATA_W'(64'h0FFF_FFFF_FFFF_FFFF));
    check("short_t_cnt", DATA_W'(trimmed_frames), DATA_W'(4));

    // Minimum header, 200B frame: L=34, beats 1..3 swallowed.
    run_one(make_frame(200, 16'h0800, 16'd20));
    check("t20_beats", DATA_W'(out_beats), DATA_W'(1));
    check("t20_keep", DATA_W'(last_out_keep), DATA_W'(64'h0000_0003_FFFF_FFFF));
    check("t20_cnt", DATA_W'(trimmed_frames), DATA_W'(5));
    exp_trimmed = 32'd5;

    // Mixed random traffic with 50% downstream stalls and input gaps.
    stall_en = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      len  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1000, 1518))
                                          : int'($urandom_range(60, 700));
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        fr = make_frame(len, 16'h0806, 16'($urandom));
      end else if (kind == 2) begin
        fr = make_frame(len, 16'h86DD, 16'($urandom));
      end else begin
        case ($urandom_range(0, 3))
          0:       t = 16'($urandom_range(20, len - 15));
          1:       t = 16'(len - 14);
          2:       t = 16'(len - 14 + int'($urandom_range(1, 100)));
          default: t = 16'($urandom_range(0, 19));
        endcase
        fr = make_frame(len, 16'h0800, t);
      end
      send_frame(fr, 1'($urandom_range(0, 1)));
    end
    drain();
    check("random_cnt", DATA_W'(trimmed_frames), DATA_W'(exp_trimmed));
    check("random_sb_empty", DATA_W'(sb.size()), DATA_W'(0));
    stall_en = 1'b0;
    repeat (2) @(posedge net_clk);
    #1;

    // Reset in the middle of beat 2 of a 5-beat padded IPv4 frame.
    fr = make_frame(320, 16'h0800, 16'd200);
    push_expected(fr);
    for (int b = 0; b < 2; b++) begin
      build_beat(fr, b, d, k);
      send_beat(d, k, 1'b0);
    end
    build_beat(fr, 2, d, k);
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    @(posedge net_clk);
    #1;
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge net_clk);
    #1;
    sb.delete();
    exp_trimmed = '0;
    check("midrst_valid", DATA_W'(m_if.tvalid), DATA_W'(1'b0));
    check("midrst_keep", DATA_W'(m_if.tkeep), DATA_W'(0));
    check("midrst_cnt", DATA_W'(trimmed_frames), DATA_W'(0));
    aresetn = 1'b1;
    @(posedge net_clk);
    #1;
    run_one(make_frame(60, 16'h0806, 16'd0));
    check("post_rst_beats", DATA_W'(out_beats), DATA_W'(1));
    check("post_rst_cnt", DATA_W'(trimmed_frames), DATA_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
